// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between an instruction-fetch requester
// and a data requester. Data normally wins arbitration; an instruction that
// has waited through FAIR_LIMIT consecutive data grants is served next.
// Optional feature macro LLSC_EN adds a load-linked / store-conditional
// link register.

package memory_arbiter_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;
endpackage

module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int unsigned FAIR_LIMIT = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   // instruction requester
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   // data requester
   input  logic        dREN,
   input  logic        dWEN,
   input  logic        datomic,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   // RAM port
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate
);

   localparam int unsigned   CW       = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
   localparam logic [CW-1:0] FAIR_MAX = CW'(FAIR_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] fair_cnt_q, fair_cnt_d;

   logic d_req;
   logic d_write;
   logic d_read;
   logic ram_ok;
   logic fair_turn;
   logic d_done;
   logic i_done;
   logic sc_op;
   logic sc_fail;

   // A simultaneous read+write request is handled as a write.
   assign d_req     = dREN | dWEN;
   assign d_write   = dWEN;
   assign d_read    = dREN & ~dWEN;
   assign ram_ok    = (ramstate == ACCESS);
   assign fair_turn = iREN && (fair_cnt_q == FAIR_MAX);

`ifdef LLSC_EN
   logic        link_valid_q, link_valid_d;
   logic [31:0] link_addr_q, link_addr_d;
   logic        ll_op;

   assign sc_op   = dWEN & datomic;
   assign ll_op   = d_read & datomic;
   // An SC whose link is gone is decided without touching the RAM.
   assign sc_fail = sc_op & ~(link_valid_q && (daddr == link_addr_q));
`else
   logic unused_datomic;

   assign unused_datomic = datomic;
   assign sc_op          = 1'b0;
   assign sc_fail        = 1'b0;
`endif

   // Arbitration state and fairness counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         fair_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fair_cnt_q <= fair_cnt_d;
      end
   end

   // Next-state decode and RAM/requester output steering.
   always_comb begin
      state_d  = state_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      d_done   = 1'b0;
      i_done   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (d_req && !fair_turn) begin
               state_d = DACC;
            end else if (iREN) begin
               state_d = IACC;
            end
         end
         DACC: begin
            if (!d_req) begin
               state_d = IDLE;
            end else if (sc_fail) begin
               dwait   = 1'b0;
               d_done  = 1'b1;
               state_d = IDLE;
            end else begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramREN   = d_read;
               ramWEN   = d_write;
               if (ram_ok) begin
                  dwait   = 1'b0;
                  d_done  = 1'b1;
                  state_d = IDLE;
                  if (d_read) begin
                     dload = ramload;
                  end else if (sc_op) begin
                     dload = 32'd1;
                  end
               end
            end
         end
         IACC: begin
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramaddr = iaddr;
               ramREN  = 1'b1;
               if (ram_ok) begin
                  iwait   = 1'b0;
                  iload   = ramload;
                  i_done  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Count data grants taken while an instruction fetch is waiting.
   always_comb begin
      fair_cnt_d = fair_cnt_q;
      if (!iREN || i_done) begin
         fair_cnt_d = '0;
      end else if (d_done && (fair_cnt_q != FAIR_MAX)) begin
         fair_cnt_d = fair_cnt_q + 1'b1;
      end
   end

`ifdef LLSC_EN
   // Link register: set by LL, consumed by a successful SC, broken by a
   // completed plain write to the linked address.
   always_comb begin
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      if (d_done) begin
         if (ll_op) begin
            link_valid_d = 1'b1;
            link_addr_d  = daddr;
         end else if (sc_op) begin
            if (!sc_fail) begin
               link_valid_d = 1'b0;
            end
         end else if (d_write && (daddr == link_addr_q)) begin
            link_valid_d = 1'b0;
         end
      end
   end

   // Link register storage.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
      end else begin
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
      end
   end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a random
// two-requester phase, checked against a word-level memory model.

module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   localparam int unsigned FL = 2;

   logic        CLK  = 1'b0;
   logic        nRST = 1'b1;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic        datomic;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // RAM responder state
   logic [31:0] ram_mem [256];
   int unsigned rcnt;
   int unsigned rlat;
   logic        rerr;
   logic        rand_mode;
   int unsigned fix_lat;
   logic        fix_err;
   int unsigned eff_lat;
   logic        eff_err;

   // reference model state
   logic [31:0] ref_mem [256];
   logic        m_lv;
   logic [31:0] m_la;

   memory_arbiter #(.FAIR_LIMIT(FL)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr),
      .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] seed_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      if (i == 16) return 32'h8C01_0004;
      return {8'hA5, b, ~b, 8'h3C};
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      return {22'b0, w, 2'b00};
   endfunction

   // RAM: request held for eff_lat cycles (BUSY or ERROR) then ACCESS.
   always_comb begin
      eff_lat = rand_mode ? rlat : fix_lat;
      eff_err = rand_mode ? rerr : fix_err;
      if (!(ramREN || ramWEN))  ramstate = FREE;
      else if (rcnt >= eff_lat) ramstate = ACCESS;
      else if (eff_err)         ramstate = ERROR;
      else                      ramstate = BUSY;
      ramload = ramREN ? ram_mem[ramaddr[9:2]] : 32'h0;
   end

   // RAM storage, latency counter and per-access random latency.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= seed_word(i);
         rcnt <= 0;
         rlat <= 0;
         rerr <= 1'b0;
      end else begin
         if ((ramREN || ramWEN) && ramstate != ACCESS) begin
            rcnt <= rcnt + 1;
         end else begin
            rcnt <= 0;
            rlat <= $urandom_range(0, 3);
            rerr <= ($urandom_range(0, 3) == 0);
         end
         if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr[9:2]] <= ramstore;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask

   // One data transaction; expected results come from the word-level model.
   task automatic dop(input string tag, input logic ren, input logic wen,
                      input logic atm, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] exp_ld;
      logic [31:0] got;
      logic        is_sc;
      logic        is_ll;
      logic        fail_sc;
      logic        done;
      int unsigned cyc;
      int unsigned wcyc;
      is_sc   = 1'b0;
      is_ll   = 1'b0;
      fail_sc = 1'b0;
      exp_ld  = 32'h0;
`ifdef LLSC_EN
      is_sc = wen & atm;
      is_ll = ren & ~wen & atm;
`endif
      if (is_sc) begin
         if (m_lv && a == m_la) begin
            exp_ld = 32'd1;
            ref_mem[a[9:2]] = d;
            m_lv = 1'b0;
         end else begin
            fail_sc = 1'b1;
         end
      end else if (wen) begin
         ref_mem[a[9:2]] = d;
         if (a == m_la) m_lv = 1'b0;
      end else begin
         exp_ld = ref_mem[a[9:2]];
         if (is_ll) begin
            m_lv = 1'b1;
            m_la = a;
         end
      end
      @(posedge CLK); #1;
      dREN = ren; dWEN = wen; datomic = atm; daddr = a; dstore = d;
      cyc = 0; wcyc = 0; done = 1'b0; got = 32'h0;
      while (!done && cyc < 64) begin
         @(negedge CLK);
         cyc++;
         if (ramWEN) wcyc++;
         if (!dwait) begin
            done = 1'b1;
            got  = dload;
         end
      end
      @(posedge CLK); #1;
      dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
      chk1({tag, "_done"}, done, 1'b1);
      chk({tag, "_dload"}, got, exp_ld);
      chk({tag, "_cycles"}, cyc, fail_sc ? 32'd2 : 32'd2 + fix_lat);
      chk({tag, "_wen_cycles"}, wcyc, (wen && !fail_sc) ? 32'd1 + fix_lat : 32'd0);
   endtask

   initial begin
      logic [7:0]  exp_g;
      logic [7:0]  got_g;
      int unsigned n;
      int unsigned cyc;
      int unsigned streak;
      int unsigned lowcnt;
      int unsigned mism;
      int unsigned c;
      logic        i_act, d_act, d_ren, d_wen;
      logic [31:0] i_a, d_a, d_v;
      int unsigned i_age, d_age, k;

      iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
      daddr = '0; dstore = '0;
      rand_mode = 1'b0; fix_lat = 0; fix_err = 1'b0;
      m_lv = 1'b0; m_la = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

      // reset: outputs idle even with requests presented
      #1 nRST = 1'b0;
      repeat (2) @(negedge CLK);
      iREN = 1'b1; iaddr = 32'h40; dWEN = 1'b1; daddr = 32'h123; dstore = 32'hFFFF;
      @(negedge CLK);
      chk1("rst_ramREN", ramREN, 1'b0);
      chk1("rst_ramWEN", ramWEN, 1'b0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_ramstore", ramstore, 32'h0);
      chk("rst_iload", iload, 32'h0);
      chk("rst_dload", dload, 32'h0);
      chk1("rst_iwait", iwait, 1'b1);
      chk1("rst_dwait", dwait, 1'b1);
      @(posedge CLK); #1;
      iREN = 1'b0; dWEN = 1'b0; iaddr = '0; daddr = '0; dstore = '0;
      @(posedge CLK); #1;
      nRST = 1'b1;

      // instruction fetch with one BUSY cycle
      fix_lat = 1;
      @(posedge CLK); #1;
      iREN = 1'b1; iaddr = 32'h40;
      @(negedge CLK);
      chk1("rd_c1_iwait", iwait, 1'b1);
      chk1("rd_c1_ramREN", ramREN, 1'b0);
      @(negedge CLK);
      chk1("rd_c2_iwait", iwait, 1'b1);
      chk1("rd_c2_ramREN", ramREN, 1'b1);
      chk1("rd_c2_ramWEN", ramWEN, 1'b0);
      chk("rd_c2_ramaddr", ramaddr, 32'h40);
      chk("rd_c2_iload", iload, 32'h0);
      @(negedge CLK);
      chk1("rd_c3_iwait", iwait, 1'b0);
      chk("rd_c3_iload", iload, 32'h8C01_0004);
      @(posedge CLK); #1;
      iREN = 1'b0;

      // withdrawn fetch: no completion, RAM request drops
      fix_lat = 5;
      @(posedge CLK); #1;
      iREN = 1'b1; iaddr = 32'h44;
      @(negedge CLK); @(negedge CLK);
      chk1("wd_ramREN_on", ramREN, 1'b1);
      @(posedge CLK); #1;
      iREN = 1'b0;
      lowcnt = 0;
      repeat (3) begin
         @(negedge CLK);
         if (!iwait || ramREN) lowcnt++;
      end
      chk("wd_no_activity", lowcnt, 0);

      // write with three ERROR cycles then ACCESS
      fix_lat = 3; fix_err = 1'b1;
      dop("err_wr", 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD);
      lowcnt = 0;
      repeat (3) begin
         @(negedge CLK);
         if (!dwait || ramWEN) lowcnt++;
      end
      chk("err_single_completion", lowcnt, 0);
      fix_lat = 0; fix_err = 1'b0;
      dop("err_rd", 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
      dop("both_wr", 1'b1, 1'b1, 1'b0, 32'h300, 32'h1234_5678);
      dop("both_rd", 1'b1, 1'b0, 1'b0, 32'h300, 32'h0);

      // fairness: both requesters held, zero-wait RAM
      @(posedge CLK); #1;
      iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h104;
      n = 0; cyc = 0; streak = 0;
      while (n < 6 && cyc < 40) begin
         @(negedge CLK);
         cyc++;
         if (!dwait || !iwait) begin
            exp_g = (streak == FL) ? "I" : "D";
            got_g = !dwait ? "D" : "I";
            chk("fair_grant", {24'h0, got_g}, {24'h0, exp_g});
            if (exp_g == "D") streak++;
            else              streak = 0;
            if (!dwait) chk("fair_dload", dload, ref_mem[8'h41]);
            else        chk("fair_iload", iload, ref_mem[8'h20]);
            n++;
            if (n == 6) chk("fair_last_cycle", cyc, 12);
         end
      end
      chk("fair_count", n, 6);
      @(posedge CLK); #1;
      iREN = 1'b0; dREN = 1'b0;

      // load-linked / store-conditional sequences
      fix_lat = 1;
      dop("ll1", 1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
      dop("sc1", 1'b0, 1'b1, 1'b1, 32'h200, 32'h5);
      dop("sc2", 1'b0, 1'b1, 1'b1, 32'h200, 32'h7);
      dop("rd_sc", 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
      dop("ll2", 1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
      dop("st_plain", 1'b0, 1'b1, 1'b0, 32'h200, 32'h9);
      dop("sc3", 1'b0, 1'b1, 1'b1, 32'h200, 32'hB);
      dop("rd_st", 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);

      // random traffic from both requesters, random RAM latency/errors
      rand_mode = 1'b1;
      i_act = 1'b0; d_act = 1'b0; c = 0;
      i_a = '0; d_a = '0; d_v = '0; i_age = 0; d_age = 0; d_ren = 1'b0; d_wen = 1'b0;
      while (c < 400 || ((i_act || d_act) && c < 480)) begin
         @(posedge CLK); #1;
         if (!i_act) begin
            iREN = 1'b0;
            if (c < 400 && $urandom_range(0, 2) != 0) begin
               i_act = 1'b1; i_age = 0; i_a = rand_addr();
               iREN = 1'b1; iaddr = i_a;
            end
         end
         if (!d_act) begin
            dREN = 1'b0; dWEN = 1'b0;
            if (c < 400 && $urandom_range(0, 2) != 0) begin
               d_act = 1'b1; d_age = 0; d_a = rand_addr(); d_v = $urandom();
               k = $urandom_range(0, 3);
               d_ren = (k != 1);
               d_wen = (k == 1 || k == 3);
               dREN = d_ren; dWEN = d_wen; daddr = d_a; dstore = d_v;
            end
         end
         @(negedge CLK);
         if (i_act) i_age++;
         if (d_act) d_age++;
         chk1("rnd_one_in_flight", !iwait && !dwait, 1'b0);
         chk1("rnd_rw_excl", ramREN && ramWEN, 1'b0);
         if (!iwait) begin
            chk1("rnd_i_owner", i_act, 1'b1);
            chk("rnd_iload", iload, ref_mem[i_a[9:2]]);
            chk1("rnd_i_lat_min", i_age >= 2, 1'b1);
            i_act = 1'b0;
         end else begin
            chk("rnd_iload_zero", iload, 32'h0);
         end
         if (!dwait) begin
            chk1("rnd_d_owner", d_act, 1'b1);
            chk1("rnd_d_lat_min", d_age >= 2, 1'b1);
            if (d_wen) begin
               chk("rnd_dload_wr", dload, 32'h0);
               ref_mem[d_a[9:2]] = d_v;
               if (d_a == m_la) m_lv = 1'b0;
            end else begin
               chk("rnd_dload_rd", dload, ref_mem[d_a[9:2]]);
            end
            d_act = 1'b0;
         end else begin
            chk("rnd_dload_zero", dload, 32'h0);
         end
         if (i_act && i_age > 40) begin
            chk("rnd_i_timeout", i_age, 40);
            i_act = 1'b0;
         end
         if (d_act && d_age > 40) begin
            chk("rnd_d_timeout", d_age, 40);
            d_act = 1'b0;
         end
         c++;
      end
      chk1("rnd_drained", i_act || d_act, 1'b0);
      @(posedge CLK); #1;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      rand_mode = 1'b0;
      @(negedge CLK);
      mism = 0;
      for (int i = 0; i < 256; i++) if (ram_mem[i] !== ref_mem[i]) mism++;
      chk("mem_image", mism, 0);

      // reset in the middle of a data write
      fix_lat = 6;
      @(posedge CLK); #1;
      dWEN = 1'b1; daddr = 32'h104; dstore = 32'hBEEF; iREN = 1'b1; iaddr = 32'h40;
      @(negedge CLK); @(negedge CLK);
      chk1("rstmid_pre_ramWEN", ramWEN, 1'b1);
      @(posedge CLK); #1;
      nRST = 1'b0;
      #1;
      chk1("rstmid_async_ramWEN", ramWEN, 1'b0);
      chk("rstmid_async_ramaddr", ramaddr, 32'h0);
      chk1("rstmid_async_dwait", dwait, 1'b1);
      @(posedge CLK); #1;
      chk1("rstmid_edge_ramWEN", ramWEN, 1'b0);
      chk1("rstmid_edge_ramREN", ramREN, 1'b0);
      chk1("rstmid_edge_dwait", dwait, 1'b1);
      chk1("rstmid_edge_iwait", iwait, 1'b1);
      dWEN = 1'b0; iREN = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(negedge CLK);
      chk1("rstmid_after_ramWEN", ramWEN, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
